// File: rtl/frame_draw_ctrl.sv
// -----------------------------------------------------------------------------
// frame_draw_ctrl
//
// Game-frame sequencer and pixel-plot stage that sits between the paddles
// block and the VGA adapter. After reset it sweeps the whole screen with the
// background colour. It then loops once per 60 Hz period:
//   - on the falling edge of sixtyhz_clk, erase both paddles at their current
//     positions;
//   - wait for the rising edge, on which the paddles block moves them;
//   - redraw both paddles at the new positions.
//
// Ports:
//   clk          system clock (50 MHz)
//   reset        synchronous, active-high reset
//   sixtyhz_clk  60 Hz square wave, asynchronous to clk
//   pause        level request to freeze paddle motion
//   px_in        paddle pixel x from the paddles block
//   py_in        paddle pixel y from the paddles block
//   state        frame state code to the paddles block
//   x_out        pixel x to the VGA adapter
//   y_out        pixel y to the VGA adapter
//   colour       pixel colour to the VGA adapter
//   plot         write enable to the VGA adapter
//   frame_done   one-cycle pulse after each completed draw pass
// -----------------------------------------------------------------------------
module frame_draw_ctrl #(
    parameter int         SCREEN_W      = 160,
    parameter int         SCREEN_H      = 120,
    parameter int         PASS_CYCLES   = 43,
    parameter logic [2:0] PADDLE_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR     = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sixtyhz_clk,
    input  logic       pause,
    input  logic [7:0] px_in,
    input  logic [6:0] py_in,
    output logic [2:0] state,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        ST_CLEAR     = 3'd0,
        ST_WAIT_FALL = 3'd1,
        ST_ERASE     = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_DRAW      = 3'd4,
        ST_PAUSE     = 3'd5
    } fsm_t;

    localparam logic [7:0] CX_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] CY_LAST = 7'(SCREEN_H - 1);
    localparam logic [5:0] PC_LAST = 6'(PASS_CYCLES - 1);

    // Code the paddles block sees; ERASE and DRAW share 4 so the paddles
    // block streams its pixels identically in both passes.
    function automatic logic [2:0] state_code(input fsm_t st);
        logic [2:0] code;
        case (st)
            ST_CLEAR:     code = 3'd0;
            ST_WAIT_FALL: code = 3'd1;
            ST_ERASE:     code = 3'd4;
            ST_WAIT_RISE: code = 3'd2;
            ST_DRAW:      code = 3'd4;
            ST_PAUSE:     code = 3'd5;
            default:      code = 3'd0;
        endcase
        return code;
    endfunction

    fsm_t       fsm_r;
    fsm_t       fsm_nxt_s;
    logic [7:0] cx_r;
    logic [7:0] cx_nxt_s;
    logic [6:0] cy_r;
    logic [6:0] cy_nxt_s;
    logic [5:0] pc_r;
    logic [5:0] pc_nxt_s;
    logic       s1_r;
    logic       s2_r;
    logic       s3_r;
    logic       rise_s;
    logic       fall_s;
    logic [2:0] state_r;
    logic [7:0] x_r;
    logic [7:0] x_nxt_s;
    logic [6:0] y_r;
    logic [6:0] y_nxt_s;
    logic [2:0] colour_r;
    logic [2:0] colour_nxt_s;
    logic       plot_r;
    logic       plot_nxt_s;
    logic       frame_done_r;
    logic       frame_done_nxt_s;

    // Two-flop synchroniser for sixtyhz_clk plus a history flop for edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= sixtyhz_clk;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise_s = s2_r & ~s3_r;
    assign fall_s = ~s2_r & s3_r;

    // FSM state and sweep/pass counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_r <= ST_CLEAR;
            cx_r  <= 8'd0;
            cy_r  <= 7'd0;
            pc_r  <= 6'd0;
        end else begin
            fsm_r <= fsm_nxt_s;
            cx_r  <= cx_nxt_s;
            cy_r  <= cy_nxt_s;
            pc_r  <= pc_nxt_s;
        end
    end

    // Next-state, counter and plot-request decode.
    always_comb begin
        fsm_nxt_s        = fsm_r;
        cx_nxt_s         = cx_r;
        cy_nxt_s         = cy_r;
        pc_nxt_s         = pc_r;
        x_nxt_s          = x_r;
        y_nxt_s          = y_r;
        colour_nxt_s     = colour_r;
        plot_nxt_s       = 1'b0;
        frame_done_nxt_s = 1'b0;

        case (fsm_r)
            ST_CLEAR: begin
                x_nxt_s      = cx_r;
                y_nxt_s      = cy_r;
                colour_nxt_s = BG_COLOUR;
                plot_nxt_s   = 1'b1;
                if (cx_r == CX_LAST) begin
                    cx_nxt_s = 8'd0;
                    if (cy_r == CY_LAST) begin
                        cy_nxt_s  = 7'd0;
                        fsm_nxt_s = ST_WAIT_FALL;
                    end else begin
                        cy_nxt_s = cy_r + 7'd1;
                    end
                end else begin
                    cx_nxt_s = cx_r + 8'd1;
                end
            end

            ST_WAIT_FALL: begin
                // pause outranks a coincident falling edge.
                if (pause) begin
                    fsm_nxt_s = ST_PAUSE;
                end else if (fall_s) begin
                    fsm_nxt_s = ST_ERASE;
                    pc_nxt_s  = 6'd0;
                end else begin
                    fsm_nxt_s = ST_WAIT_FALL;
                end
            end

            ST_ERASE, ST_DRAW: begin
                // pc=0 is the paddles pipeline-fill cycle: nothing valid yet.
                x_nxt_s      = px_in;
                y_nxt_s      = py_in;
                colour_nxt_s = (fsm_r == ST_DRAW) ? PADDLE_COLOUR : BG_COLOUR;
                plot_nxt_s   = (pc_r >= 6'd1);
                if (pc_r == PC_LAST) begin
                    pc_nxt_s = 6'd0;
                    if (fsm_r == ST_DRAW) begin
                        fsm_nxt_s        = ST_WAIT_FALL;
                        frame_done_nxt_s = 1'b1;
                    end else begin
                        fsm_nxt_s = ST_WAIT_RISE;
                    end
                end else begin
                    pc_nxt_s = pc_r + 6'd1;
                end
            end

            ST_WAIT_RISE: begin
                if (rise_s) begin
                    fsm_nxt_s = ST_DRAW;
                    pc_nxt_s  = 6'd0;
                end else begin
                    fsm_nxt_s = ST_WAIT_RISE;
                end
            end

            ST_PAUSE: begin
                if (!pause) begin
                    fsm_nxt_s = ST_WAIT_FALL;
                end else begin
                    fsm_nxt_s = ST_PAUSE;
                end
            end

            default: begin
                fsm_nxt_s = ST_CLEAR;
                cx_nxt_s  = 8'd0;
                cy_nxt_s  = 7'd0;
                pc_nxt_s  = 6'd0;
            end
        endcase
    end

    // Registered outputs to the paddles block and the VGA adapter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= 3'd0;
            x_r          <= 8'd0;
            y_r          <= 7'd0;
            colour_r     <= 3'd0;
            plot_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_code(fsm_nxt_s);
            x_r          <= x_nxt_s;
            y_r          <= y_nxt_s;
            colour_r     <= colour_nxt_s;
            plot_r       <= plot_nxt_s;
            frame_done_r <= frame_done_nxt_s;
        end
    end

    assign state      = state_r;
    assign x_out      = x_r;
    assign y_out      = y_r;
    assign colour     = colour_r;
    assign plot       = plot_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_frame_draw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_draw_ctrl
//
// Directed bench for frame_draw_ctrl. A small paddles model streams paddle
// pixels while state==4: pc=1..21 gives (5, p1y..p1y+20) and pc=22..42 gives
// (155, p2y..p2y+20). Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_frame_draw_ctrl;

    logic       clk;
    logic       reset;
    logic       sixtyhz_clk;
    logic       pause;
    logic [7:0] px_in;
    logic [6:0] py_in;
    logic [2:0] state;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;
    logic       frame_done;

    int         checks;
    int         errors;
    int         tb_pc;
    logic [6:0] p1y;
    logic [6:0] p2y;

    frame_draw_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .sixtyhz_clk (sixtyhz_clk),
        .pause       (pause),
        .px_in       (px_in),
        .py_in       (py_in),
        .state       (state),
        .x_out       (x_out),
        .y_out       (y_out),
        .colour      (colour),
        .plot        (plot),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Paddles model: pass cycle counter follows the state==4 window.
    always @(posedge clk) begin
        if (state == 3'd4) tb_pc <= tb_pc + 1;
        else               tb_pc <= 0;
    end

    // Expected paddle pixel {y, x} for pass index j (1..42).
    function automatic logic [14:0] exp_pix(input int j, input logic [6:0] a, input logic [6:0] b);
        logic [7:0] x;
        logic [6:0] y;
        if (j >= 1 && j <= 21) begin
            x = 8'd5;
            y = a + 7'(j - 1);
        end else if (j >= 22 && j <= 42) begin
            x = 8'd155;
            y = b + 7'(j - 22);
        end else begin
            x = 8'hAA;
            y = 7'h55;
        end
        return {y, x};
    endfunction

    always_comb begin
        {py_in, px_in} = exp_pix(tb_pc, p1y, p2y);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full 160x120 background sweep, starting the negedge after reset drops.
    task automatic check_clear(input string tag);
        for (int i = 0; i < 19200; i++) begin
            @(negedge clk);
            chk(tag, {13'd0, plot, colour, y_out, x_out},
                {13'd0, 1'b1, 3'b000, 7'(i / 160), 8'(i % 160)});
        end
        @(negedge clk);
        chk({tag, "_end_state"}, {29'd0, state}, 32'd1);
        chk({tag, "_end_plot"}, {31'd0, plot}, 32'd0);
    endtask

    // One erase/draw pass, from waiting for state 4 to the plot going idle.
    task automatic run_pass(input string tag, input logic [2:0] col, input logic [2:0] next_st,
                            input logic done_exp, input int pause_at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state !== 3'd4 && n < 20);
        chk({tag, "_start"}, {29'd0, state}, 32'd4);
        chk({tag, "_fill_plot"}, {31'd0, plot}, 32'd0);
        for (int k = 1; k <= 42; k++) begin
            if (k == pause_at) pause = 1'b1;
            @(negedge clk);
            chk({tag, "_state"}, {29'd0, state}, 32'd4);
            chk({tag, "_plot"}, {31'd0, plot}, {31'd0, (k >= 2)});
            chk({tag, "_done_low"}, {31'd0, frame_done}, 32'd0);
            if (k >= 2)
                chk({tag, "_pix"}, {14'd0, colour, y_out, x_out}, {14'd0, col, exp_pix(k - 1, p1y, p2y)});
        end
        @(negedge clk);
        chk({tag, "_next_state"}, {29'd0, state}, {29'd0, next_st});
        chk({tag, "_last_plot"}, {31'd0, plot}, 32'd1);
        chk({tag, "_last_pix"}, {14'd0, colour, y_out, x_out}, {14'd0, col, exp_pix(42, p1y, p2y)});
        chk({tag, "_done"}, {31'd0, frame_done}, {31'd0, done_exp});
        @(negedge clk);
        chk({tag, "_idle_plot"}, {31'd0, plot}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        int n;
        checks      = 0;
        errors      = 0;
        tb_pc       = 0;
        p1y         = 7'd75;
        p2y         = 7'd75;
        reset       = 1'b1;
        sixtyhz_clk = 1'b1;
        pause       = 1'b0;

        // Reset state, then the full clear sweep.
        repeat (2) @(negedge clk);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pix", {13'd0, plot, colour, y_out, x_out}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        check_clear("clear1");

        // Falling edge: erase at the initial positions.
        sixtyhz_clk = 1'b0;
        run_pass("erase1", 3'b000, 3'd2, 1'b0, 0);

        // Rising edge: paddle 1 has moved down a row; draw.
        p1y = 7'd76;
        sixtyhz_clk = 1'b1;
        run_pass("draw1", 3'b111, 3'd1, 1'b1, 0);

        // Pause in WAIT_FALL: edges are ignored, no plots.
        pause = 1'b1;
        @(negedge clk);
        chk("pause_enter", {29'd0, state}, 32'd5);
        for (int t = 0; t < 4; t++) begin
            sixtyhz_clk = ~sixtyhz_clk;
            repeat (8) begin
                @(negedge clk);
                chk("pause_hold_state", {29'd0, state}, 32'd5);
                chk("pause_hold_plot", {31'd0, plot}, 32'd0);
            end
        end
        pause = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("unpause_state", {29'd0, state}, 32'd1);
        end
        sixtyhz_clk = 1'b0;
        run_pass("erase2", 3'b000, 3'd2, 1'b0, 0);

        // Reset at pc=20 of a draw pass restarts the clear.
        sixtyhz_clk = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state !== 3'd4 && n < 20);
        chk("draw2_start", {29'd0, state}, 32'd4);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_state", {29'd0, state}, 32'd0);
        chk("midrst_pix", {13'd0, plot, colour, y_out, x_out}, 32'd0);
        chk("midrst_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        check_clear("clear2");

        // pause and a detected fall in the same WAIT_FALL cycle.
        @(negedge clk);
        sixtyhz_clk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        chk("pause_vs_fall", {29'd0, state}, 32'd5);
        pause = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("no_erase_after_pause", {29'd0, state}, 32'd1);
        end

        // A rise in WAIT_FALL is ignored.
        sixtyhz_clk = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rise_ignored", {29'd0, state}, 32'd1);
        end

        // pause raised mid-erase: the pass still completes.
        sixtyhz_clk = 1'b0;
        run_pass("erase3", 3'b000, 3'd2, 1'b0, 10);
        repeat (5) begin
            @(negedge clk);
            chk("wait_rise_no_pause", {29'd0, state}, 32'd2);
        end
        pause = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
